// File: rtl/button_conditioner_pkg.sv
// Shared timing constants and repeat-FSM state type for the button conditioner.
package button_conditioner_pkg;

  localparam int unsigned CLK_FREQ_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS      = 10;
  localparam int unsigned REPEAT_DELAY_MS  = 300;
  localparam int unsigned REPEAT_PERIOD_MS = 100;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_FREQ_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES_DEF = ms_to_cycles(DEBOUNCE_MS);
  localparam int unsigned REPEAT_DELAY_DEF    = ms_to_cycles(REPEAT_DELAY_MS);
  localparam int unsigned REPEAT_PERIOD_DEF   = ms_to_cycles(REPEAT_PERIOD_MS);

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: synchronizer, counter debounce, press/release pulses and
// optional typematic auto-repeat on the action strobe.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic action_o
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   action_q;
  logic [REP_W-1:0]       rep_cnt_q;
  rep_state_e             state_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Level flips only after the synchronized input has disagreed for the full window.
  always_comb begin
    db_cnt_d  = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_s != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d   = sync_s;
        press_d   = sync_s;
        release_d = ~sync_s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Repeat FSM reacts to the same-edge press/release so action aligns with press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REP_IDLE;
      rep_cnt_q <= '0;
      action_q  <= 1'b0;
    end else begin
      action_q <= 1'b0;
      case (state_q)
        REP_IDLE: begin
          if (press_d) begin
            action_q <= 1'b1;
            if (REPEAT_EN) begin
              state_q   <= REP_DELAY;
              rep_cnt_q <= REP_W'(REPEAT_DELAY - 1);
            end
          end
        end
        REP_DELAY, REP_REPEAT: begin
          if (release_d) begin
            state_q   <= REP_IDLE;
            rep_cnt_q <= '0;
          end else if (rep_cnt_q == '0) begin
            action_q  <= 1'b1;
            state_q   <= REP_REPEAT;
            rep_cnt_q <= REP_W'(REPEAT_PERIOD - 1);
          end else begin
            rep_cnt_q <= rep_cnt_q - REP_W'(1);
          end
        end
        default: begin
          state_q   <= REP_IDLE;
          rep_cnt_q <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign action_o  = action_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: one independent button_channel per input.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned         CHANNELS        = 4,
  parameter int unsigned         SYNC_STAGES     = 3,
  parameter int unsigned         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned         REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned         REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter logic [CHANNELS-1:0] REPEAT_MASK     = CHANNELS'(4'b0011)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] action_o
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .action_o (action_o[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a cycle-stamped pulse scoreboard.
module tb_button_conditioner;

  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] btn;
  logic [CH-1:0] level, press, rel, action;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [CH-1:0] p;
    logic [CH-1:0] r;
    logic [CH-1:0] a;
  } ev_t;

  ev_t q[$];
  ev_t ev;

  button_conditioner #(
    .CHANNELS       (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (4'b0001)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_i    (btn),
    .level_o  (level),
    .press_o  (press),
    .release_o(rel),
    .action_o (action)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [CH-1:0] p, input logic [CH-1:0] r,
                      input logic [CH-1:0] a);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.a = a;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses must occur exactly in the cycles the scoreboard expects, and nowhere else.
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc <= cyc) begin
      ev = q.pop_front();
      chk("pulse_cycle", 32'(cyc), 32'(ev.cyc));
      chk("press",   32'(press),  32'(ev.p));
      chk("release", 32'(rel),    32'(ev.r));
      chk("action",  32'(action), 32'(ev.a));
    end else if ({press, rel, action} !== '0) begin
      chk("unexpected_pulse", 32'({press, rel, action}), 32'(0));
    end
  end

  initial begin
    int c;
    int p;
    reset = 1'b1;
    btn   = '0;
    tick(3);
    chk("rst_level",   32'(level),  32'(0));
    chk("rst_press",   32'(press),  32'(0));
    chk("rst_release", 32'(rel),    32'(0));
    chk("rst_action",  32'(action), 32'(0));
    reset = 1'b0;
    tick(2);

    // Clean press/release on a non-repeating channel
    c = cyc;
    btn[1] = 1'b1;
    push(c + 6, 4'b0010, 4'b0000, 4'b0010);
    tick(5);
    chk("t1_level_before", 32'(level), 32'(0));
    tick(15);
    chk("t1_level_held", 32'(level), 32'b0010);
    c = cyc;
    btn[1] = 1'b0;
    push(c + 6, 4'b0000, 4'b0010, 4'b0000);
    tick(10);
    chk("t1_level_rel", 32'(level), 32'(0));

    // Glitch shorter than the debounce window
    btn[2] = 1'b1;
    tick(3);
    btn[2] = 1'b0;
    tick(10);
    chk("t2_level", 32'(level), 32'(0));

    // Bounce then hold on the repeating channel, then release
    btn[0] = 1'b1; tick(1);
    btn[0] = 1'b0; tick(1);
    btn[0] = 1'b1; tick(1);
    btn[0] = 1'b0; tick(1);
    btn[0] = 1'b1;
    p = cyc + 6;
    push(p,      4'b0001, 4'b0000, 4'b0001);
    push(p + 10, 4'b0000, 4'b0000, 4'b0001);
    push(p + 13, 4'b0000, 4'b0000, 4'b0001);
    push(p + 16, 4'b0000, 4'b0000, 4'b0001);
    push(p + 19, 4'b0000, 4'b0000, 4'b0001);
    tick(7);
    chk("t3_level_held", 32'(level), 32'b0001);
    tick(14);
    btn[0] = 1'b0;
    push(p + 21, 4'b0000, 4'b0001, 4'b0000);
    tick(15);
    chk("t4_level_rel", 32'(level), 32'(0));

    // All channels at once, then reset mid-repeat with buttons still held
    btn = 4'b1111;
    p = cyc + 6;
    push(p,      4'b1111, 4'b0000, 4'b1111);
    push(p + 10, 4'b0000, 4'b0000, 4'b0001);
    tick(7);
    chk("t5_level", 32'(level), 32'b1111);
    tick(10);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_level",  32'(level),  32'(0));
    chk("t6_rst_pulses", 32'({press, rel, action}), 32'(0));
    reset = 1'b0;
    p = cyc + 6;
    push(p,      4'b1111, 4'b0000, 4'b1111);
    push(p + 10, 4'b0000, 4'b0000, 4'b0001);
    push(p + 13, 4'b0000, 4'b0000, 4'b0001);
    tick(14);
    btn = 4'b0000;
    push(p + 14, 4'b0000, 4'b1111, 4'b0000);
    tick(12);
    chk("t6_level_rel", 32'(level), 32'(0));

    tick(5);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
